// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared CAN constants, frame geometry and tx state encoding
package can_pkg;

    localparam logic [2:0] CAN_STUFF_RUN = 3'd5;
    localparam logic       CAN_RECESSIVE = 1'b1;
    localparam logic       CAN_DOMINANT  = 1'b0;

    // Standard data frame, 8 data bytes, SOF through EOF
    localparam int CAN_SOF_BITS    = 1;
    localparam int CAN_ID_BITS     = 11;
    localparam int CAN_CTRL_BITS   = 3;
    localparam int CAN_DLC_BITS    = 4;
    localparam int CAN_DATA_BITS   = 64;
    localparam int CAN_CRC_BITS    = 15;
    localparam int CAN_CRCDEL_BITS = 1;
    localparam int CAN_ACK_BITS    = 2;
    localparam int CAN_EOF_BITS    = 7;
    localparam int CAN_STD_FRAME_BITS = CAN_SOF_BITS + CAN_ID_BITS + CAN_CTRL_BITS + CAN_DLC_BITS
                                      + CAN_DATA_BITS + CAN_CRC_BITS + CAN_CRCDEL_BITS
                                      + CAN_ACK_BITS + CAN_EOF_BITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_STUFF = 2'd2,
        ST_DONE  = 2'd3
    } can_tx_state_e;

endpackage

// File: rtl/can_bit_timer.sv
// rtl/can_bit_timer.sv - nominal bit-time counter with end-of-bit strobe
module can_bit_timer #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_Clear,
    input  logic i_Enable,
    output logic o_Bit_End
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] clk_cnt_q;

    assign o_Bit_End = i_Enable && !i_Clear && (clk_cnt_q == LAST_CNT);

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            clk_cnt_q <= '0;
        end else if (i_Clear) begin
            clk_cnt_q <= '0;
        end else if (i_Enable) begin
            clk_cnt_q <= o_Bit_End ? '0 : clk_cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/can_stuff_tx.sv
// rtl/can_stuff_tx.sv - CAN frame serialiser with bit stuffing over the leading stuffed region
module can_stuff_tx
    import can_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int FRAME_BITS   = CAN_STD_FRAME_BITS
) (
    input  logic                  i_Clock,
    input  logic                  i_Rst_n,
    input  logic                  i_Tx_DV,
    input  logic [FRAME_BITS-1:0] i_Tx_Frame,
    input  logic [6:0]            i_Frame_Len,
    input  logic [6:0]            i_Stuff_Len,
    output logic                  o_Tx_Serial,
    output logic                  o_Tx_Active,
    output logic                  o_Stuff_Bit,
    output logic                  o_Tx_Done
);
    localparam logic [6:0] MAX_LEN = 7'(FRAME_BITS);

    can_tx_state_e         state_q;
    logic [FRAME_BITS-1:0] frame_q;
    logic [6:0]            frame_len_q;
    logic [6:0]            stuff_len_q;
    logic [6:0]            bit_idx_q;
    logic [2:0]            run_cnt_q;
    logic                  last_bit_q;
    logic                  serial_q;
    logic                  active_q;
    logic                  stuff_bit_q;
    logic                  done_q;

    logic       bit_end;
    logic [6:0] frame_len_in;
    logic [6:0] stuff_len_in;
    logic [6:0] next_idx;
    logic       next_bit;
    logic       stuff_now;
    logic       at_last;

    // Length sanitising at latch time: zero means one bit, stuffed region never exceeds the frame
    assign frame_len_in = (i_Frame_Len == 7'd0)   ? 7'd1    :
                          (i_Frame_Len > MAX_LEN) ? MAX_LEN : i_Frame_Len;
    assign stuff_len_in = (i_Stuff_Len > frame_len_in) ? frame_len_in : i_Stuff_Len;

    assign next_idx  = bit_idx_q + 7'd1;
    assign next_bit  = frame_q[next_idx];
    assign at_last   = (bit_idx_q == frame_len_q - 7'd1);
    assign stuff_now = (state_q == ST_DATA) && (bit_idx_q < stuff_len_q)
                       && (run_cnt_q == CAN_STUFF_RUN);

    can_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
        .i_Clock  (i_Clock),
        .i_Rst_n  (i_Rst_n),
        .i_Clear  ((state_q == ST_IDLE) || (state_q == ST_DONE)),
        .i_Enable ((state_q == ST_DATA) || (state_q == ST_STUFF)),
        .o_Bit_End(bit_end)
    );

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= ST_IDLE;
            frame_q     <= '0;
            frame_len_q <= '0;
            stuff_len_q <= '0;
            bit_idx_q   <= '0;
            run_cnt_q   <= '0;
            last_bit_q  <= CAN_DOMINANT;
            serial_q    <= CAN_RECESSIVE;
            active_q    <= 1'b0;
            stuff_bit_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_Tx_DV) begin
                        state_q     <= ST_DATA;
                        frame_q     <= i_Tx_Frame;
                        frame_len_q <= frame_len_in;
                        stuff_len_q <= stuff_len_in;
                        bit_idx_q   <= '0;
                        run_cnt_q   <= 3'd1;
                        last_bit_q  <= i_Tx_Frame[0];
                        serial_q    <= i_Tx_Frame[0];
                        active_q    <= 1'b1;
                        stuff_bit_q <= 1'b0;
                    end
                end
                ST_DATA, ST_STUFF: begin
                    if (bit_end) begin
                        if (stuff_now) begin
                            state_q     <= ST_STUFF;
                            serial_q    <= ~last_bit_q;
                            last_bit_q  <= ~last_bit_q;
                            run_cnt_q   <= 3'd1;
                            stuff_bit_q <= 1'b1;
                        end else if (at_last) begin
                            state_q     <= ST_DONE;
                            serial_q    <= CAN_RECESSIVE;
                            active_q    <= 1'b0;
                            stuff_bit_q <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            state_q     <= ST_DATA;
                            bit_idx_q   <= next_idx;
                            serial_q    <= next_bit;
                            stuff_bit_q <= 1'b0;
                            // Raw trailing bits leave the run tracker untouched
                            if (next_idx < stuff_len_q) begin
                                if (next_bit == last_bit_q) begin
                                    run_cnt_q <= run_cnt_q + 3'd1;
                                end else begin
                                    run_cnt_q  <= 3'd1;
                                    last_bit_q <= next_bit;
                                end
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_Tx_Serial = serial_q;
    assign o_Tx_Active = active_q;
    assign o_Stuff_Bit = stuff_bit_q;
    assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_can_stuff_tx.sv
// tb/tb_can_stuff_tx.sv - randomized self-checking bench for can_stuff_tx against a stuffing model
module tb_can_stuff_tx;
    localparam int C  = 4;
    localparam int FB = 108;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tx_dv = 1'b0;
    logic [FB-1:0] tx_frame = '0;
    logic [6:0]    frame_len = '0;
    logic [6:0]    stuff_len = '0;
    logic          tx_serial;
    logic          tx_active;
    logic          tx_stuff;
    logic          tx_done;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] exp_q[$];
    logic [1:0] trace[$];

    always #5 clk = ~clk;

    can_stuff_tx #(.CLKS_PER_BIT(C), .FRAME_BITS(FB)) dut (
        .i_Clock    (clk),
        .i_Rst_n    (rst_n),
        .i_Tx_DV    (tx_dv),
        .i_Tx_Frame (tx_frame),
        .i_Frame_Len(frame_len),
        .i_Stuff_Len(stuff_len),
        .o_Tx_Serial(tx_serial),
        .o_Tx_Active(tx_active),
        .o_Stuff_Bit(tx_stuff),
        .o_Tx_Done  (tx_done)
    );

    task automatic check_eq(input string tag, input int got, input int want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Wire image as a list of {bit, is_stuff}, built from the run-of-five rule
    task automatic build_exp(input logic [FB-1:0] f, input int flen_in, input int slen_in);
        int   flen;
        int   slen;
        int   run;
        logic last;
        flen = (flen_in == 0) ? 1 : ((flen_in > FB) ? FB : flen_in);
        slen = (slen_in > flen) ? flen : slen_in;
        exp_q.delete();
        run  = 0;
        last = 1'b0;
        for (int i = 0; i < flen; i++) begin
            exp_q.push_back({f[i], 1'b0});
            if (i < slen) begin
                if (run > 0 && f[i] == last) run++;
                else begin
                    run  = 1;
                    last = f[i];
                end
                if (run == 5) begin
                    exp_q.push_back({~f[i], 1'b1});
                    run  = 1;
                    last = ~f[i];
                end
            end
        end
    endtask

    function automatic logic [FB-1:0] gen_frame();
        logic [FB-1:0] f;
        logic          b;
        b = 1'($urandom);
        for (int i = 0; i < FB; i++) begin
            if ($urandom_range(0, 3) == 0) b = ~b;
            f[i] = b;
        end
        return f;
    endfunction

    function automatic int stuff_bits_seen();
        int n;
        n = 0;
        for (int i = 0; i < trace.size(); i++) if (trace[i][0]) n++;
        return n / C;
    endfunction

    // dv_at_in: -1 none, -2 pulse in the DONE cycle, -3 random cycle, else that cycle
    task automatic run_frame(input logic [FB-1:0] f, input int flen, input int slen,
                             input int dv_at_in, input string tag);
        int cyc;
        int budget;
        int done_cyc;
        int done_cnt;
        int dv_at;
        build_exp(f, flen, slen);
        trace.delete();
        budget = (exp_q.size() + 4) * C + 10;
        if (dv_at_in == -2) dv_at = exp_q.size() * C;
        else if (dv_at_in == -3) dv_at = $urandom_range(1, exp_q.size() * C);
        else dv_at = dv_at_in;

        @(negedge clk);
        tx_frame  = f;
        frame_len = 7'(flen);
        stuff_len = 7'(slen);
        tx_dv     = 1'b1;
        @(negedge clk);
        tx_dv     = 1'b0;
        tx_frame  = FB'({$urandom, $urandom, $urandom, $urandom});
        frame_len = 7'($urandom);
        stuff_len = 7'($urandom);
        check_eq({tag, " latency"}, int'(tx_active), 1);

        cyc = 0;
        done_cyc = -1;
        done_cnt = 0;
        while (cyc < budget) begin
            if (tx_active) trace.push_back({tx_serial, tx_stuff});
            if (tx_done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    check_eq({tag, " done serial"}, int'(tx_serial), 1);
                    check_eq({tag, " done active"}, int'(tx_active), 0);
                end
            end
            if (done_cyc >= 0 && cyc > done_cyc)
                check_eq({tag, " idle after done"}, int'(tx_active), 0);
            if (done_cyc >= 0 && cyc == done_cyc + 2) break;
            tx_dv = (cyc == dv_at);
            @(negedge clk);
            cyc++;
        end
        tx_dv = 1'b0;

        if (done_cyc < 0) check_eq({tag, " done seen"}, 0, 1);
        else begin
            check_eq({tag, " done time"}, done_cyc, exp_q.size() * C);
            check_eq({tag, " done count"}, done_cnt, 1);
        end
        check_eq({tag, " len"}, trace.size(), exp_q.size() * C);
        for (int k = 0; k < exp_q.size() && (k + 1) * C <= trace.size(); k++) begin
            logic [1:0] g;
            g = exp_q[k];
            for (int j = 0; j < C; j++) if (trace[k * C + j] !== exp_q[k]) g = trace[k * C + j];
            check_eq($sformatf("%s bit%0d", tag, k), int'(g), int'(exp_q[k]));
        end
    endtask

    initial begin
        logic [FB-1:0] f;

        repeat (3) @(negedge clk);
        check_eq("reset serial", int'(tx_serial), 1);
        check_eq("reset active", int'(tx_active), 0);
        check_eq("reset stuff",  int'(tx_stuff), 0);
        check_eq("reset done",   int'(tx_done), 0);
        rst_n = 1'b1;

        f = '0;
        run_frame(f, 20, 20, -1, "zeros");
        check_eq("zeros wire bits", trace.size() / C, 24);
        check_eq("zeros stuff bits", stuff_bits_seen(), 4);

        f = '0;
        f[6:0] = 7'b0111110;
        run_frame(f, 7, 7, -1, "ones");
        check_eq("ones wire bits", trace.size() / C, 8);
        check_eq("ones stuff bits", stuff_bits_seen(), 1);

        f = '0;
        f[11:6] = 6'h3f;
        run_frame(f, 12, 6, -1, "raw tail");
        check_eq("raw tail wire bits", trace.size() / C, 13);

        run_frame(gen_frame(), 60, 50, 5 * C + 1, "mid dv");
        run_frame(gen_frame(), 30, 30, -2, "done dv");
        run_frame(gen_frame(), 0, 0, -1, "len zero");
        run_frame(gen_frame(), 40, 90, -1, "stuff clamp");
        run_frame(gen_frame(), FB, 98, -1, "full");

        for (int n = 0; n < 30; n++) begin
            int fl;
            int sl;
            fl = $urandom_range(0, FB);
            sl = $urandom_range(0, fl + 3);
            run_frame(gen_frame(), fl, sl, ($urandom_range(0, 1) == 0) ? -1 : -3,
                      $sformatf("rand%0d", n));
        end

        @(negedge clk);
        tx_frame  = gen_frame();
        frame_len = 7'(FB);
        stuff_len = 7'd98;
        tx_dv     = 1'b1;
        @(negedge clk);
        tx_dv = 1'b0;
        repeat (30 * C + 1) @(negedge clk);
        check_eq("pre reset active", int'(tx_active), 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid reset serial", int'(tx_serial), 1);
        check_eq("mid reset active", int'(tx_active), 0);
        check_eq("mid reset stuff",  int'(tx_stuff), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("mid reset done", int'(tx_done), 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("post reset done", int'(tx_done), 0);
            check_eq("post reset idle", int'(tx_active), 0);
        end
        run_frame(gen_frame(), 50, 45, -1, "after reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
